alu_sequencer: RTL

- Clocked command front-end that drives the team's 8-bit combinational ALU.
- It accepts operation commands over a valid/ready handshake and drives the operands and opcode into the ALU.
- It registers the ALU result and its zero/carry flags, and holds them on a valid/ready result interface until the result is consumed.
- It keeps an accumulator so that consecutive commands can chain results. It sits between the instruction/control logic and the ALU instance.

---
 rtl/alu_sequencer_if.sv | 23 ++
 rtl/alu_sequencer.sv | 66 ++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command and result valid/ready channels (master drives cmd_*/res_ready; slave is the sequencer)
interface alu_sequencer_if #(parameter int WIDTH = 8);
  logic cmd_valid;
  logic cmd_ready;
  logic [2:0] cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic cmd_use_acc;
  logic cmd_wr_acc;
  logic res_valid;
  logic res_ready;
  logic [WIDTH-1:0] res_data;
  logic res_zero;
  logic res_carry;
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_wr_acc, res_ready,
    input cmd_ready, res_valid, res_data, res_zero, res_carry
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_wr_acc, res_ready,
    output cmd_ready, res_valid, res_data, res_zero, res_carry
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE/EXEC/RESP front-end for an 8-bit ALU; cmd/res channels on s, ALU drive/return on alu_*, plus acc, op_count, busy
module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int ACC_INIT = 0
) (
  input logic clk,
  input logic rst,
  alu_sequencer_if.slave s,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0] alu_sel,
  input logic [WIDTH-1:0] alu_out,
  input logic alu_zero,
  input logic alu_carry,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, nxt;
  logic wr_acc;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (s.cmd_valid ? EXEC : IDLE) :
          state == EXEC ? RESP :
          s.res_ready ? IDLE : RESP;
  always_comb begin
    s.cmd_ready = state == IDLE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      wr_acc <= 1'b0;
      s.res_valid <= 1'b0;
      s.res_data <= '0;
      s.res_zero <= 1'b0;
      s.res_carry <= 1'b0;
      acc <= WIDTH'(ACC_INIT);
      op_count <= '0;
    end else begin
      if (state == IDLE && s.cmd_valid) begin
        alu_a <= s.cmd_use_acc ? acc : s.cmd_a;
        alu_b <= s.cmd_b;
        alu_sel <= s.cmd_op;
        wr_acc <= s.cmd_wr_acc;
      end
      if (state == EXEC) begin
        s.res_valid <= 1'b1;
        s.res_data <= alu_out;
        s.res_zero <= alu_zero;
        s.res_carry <= alu_carry;
        if (wr_acc) acc <= alu_out;
      end
      if (state == RESP && s.res_ready) begin
        s.res_valid <= 1'b0;
        op_count <= op_count + 1'b1;
      end
    end
  end
endmodule
